// File: rtl/compare_debounce_if.sv
// Flag/status bundle between the magnitude comparator side and the debouncer.
// The master drives the comparator flags and reads back the committed relation.
interface compare_debounce_if #(
  parameter int CNT_W   = 4,
  parameter int TRANS_W = 8
);
  logic               sample_en;
  logic               gt;
  logic               lt;
  logic               eq;
  logic [1:0]         state;
  logic               changed;
  logic [CNT_W-1:0]   run_cnt;
  logic               err;
  logic [TRANS_W-1:0] trans_cnt;

  modport master (
    output sample_en, gt, lt, eq,
    input  state, changed, run_cnt, err, trans_cnt
  );

  modport slave (
    input  sample_en, gt, lt, eq,
    output state, changed, run_cnt, err, trans_cnt
  );
endinterface

// File: rtl/compare_debounce.sv
// Debounces comparator gt/lt/eq flags into a committed ABOVE/BELOW/EQUAL relation,
// with a sticky illegal-flag indicator and a wrapping commit counter.
module compare_debounce #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4,
  parameter int TRANS_W  = 8
) (
  input logic              clk,
  input logic              rst,
  compare_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    EQUAL   = 2'b00,
    BELOW   = 2'b01,
    ABOVE   = 2'b10,
    UNKNOWN = 2'b11
  } rel_t;

  rel_t               committed;
  rel_t               candidate;
  rel_t               sample_class;
  logic               illegal;
  logic               commit;
  logic [CNT_W-1:0]   run_count;
  logic [CNT_W-1:0]   run_next;
  logic [TRANS_W-1:0] trans_count;
  logic               changed_pulse;
  logic               err_flag;

  // eq only matters for detecting contradictions; gt=lt=0 alone means EQUAL
  always_comb begin
    illegal      = (bus.gt & bus.lt) | (bus.eq & (bus.gt | bus.lt));
    sample_class = EQUAL;
    if (bus.gt) begin
      sample_class = ABOVE;
    end else if (bus.lt) begin
      sample_class = BELOW;
    end
    run_next = run_count + 1'b1;
    commit   = 1'b0;
    if (bus.sample_en && !illegal && (sample_class != committed)) begin
      if (sample_class == candidate) begin
        commit = (run_next == CNT_W'(DEBOUNCE));
      end else begin
        commit = (DEBOUNCE == 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      committed     <= UNKNOWN;
      candidate     <= UNKNOWN;
      run_count     <= '0;
      trans_count   <= '0;
      changed_pulse <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      changed_pulse <= 1'b0;
      if (bus.sample_en) begin
        if (illegal) begin
          err_flag  <= 1'b1;
          run_count <= '0;
          candidate <= UNKNOWN;
        end else if (sample_class == committed) begin
          run_count <= '0;
          candidate <= UNKNOWN;
        end else if (commit) begin
          committed     <= sample_class;
          candidate     <= UNKNOWN;
          run_count     <= '0;
          trans_count   <= trans_count + 1'b1;
          changed_pulse <= 1'b1;
        end else if (sample_class == candidate) begin
          run_count <= run_next;
        end else begin
          candidate <= sample_class;
          run_count <= CNT_W'(1);
        end
      end
    end
  end

  assign bus.state     = committed;
  assign bus.changed   = changed_pulse;
  assign bus.run_cnt   = run_count;
  assign bus.err       = err_flag;
  assign bus.trans_cnt = trans_count;

endmodule

// File: tb/tb_compare_debounce.sv
// Directed bench for compare_debounce: a DEBOUNCE=4 instance for run/error/gap
// behaviour and a DEBOUNCE=1 instance for back-to-back commits and counter wrap.
module tb_compare_debounce;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   changed_seen;

  compare_debounce_if #(.CNT_W(4), .TRANS_W(8)) if4 ();
  compare_debounce_if #(.CNT_W(4), .TRANS_W(8)) if1 ();

  compare_debounce #(.DEBOUNCE(4), .CNT_W(4), .TRANS_W(8)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  compare_debounce #(.DEBOUNCE(1), .CNT_W(4), .TRANS_W(8)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one qualified sample on the DEBOUNCE=4 instance, returning #1 after the edge
  task automatic s4(input logic g, input logic l, input logic e);
    if4.sample_en = 1'b1;
    if4.gt = g;
    if4.lt = l;
    if4.eq = e;
    @(posedge clk);
    #1;
    if4.sample_en = 1'b0;
  endtask

  task automatic s1(input logic g, input logic l);
    if1.sample_en = 1'b1;
    if1.gt = g;
    if1.lt = l;
    if1.eq = 1'b0;
    @(posedge clk);
    #1;
    if1.sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    changed_seen = 0;
    rst = 1'b1;
    if4.sample_en = 1'b0; if4.gt = 1'b0; if4.lt = 1'b0; if4.eq = 1'b0;
    if1.sample_en = 1'b0; if1.gt = 1'b0; if1.lt = 1'b0; if1.eq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   32'(if4.state),     32'd3);
    chk("rst_run",     32'(if4.run_cnt),   32'd0);
    chk("rst_changed", 32'(if4.changed),   32'd0);
    chk("rst_err",     32'(if4.err),       32'd0);
    chk("rst_trans",   32'(if4.trans_cnt), 32'd0);
    rst = 1'b0;

    // UNKNOWN -> ABOVE after four GT samples
    for (int i = 1; i <= 3; i++) begin
      s4(1'b1, 1'b0, 1'b0);
      chk("gt_hold_state", 32'(if4.state),   32'd3);
      chk("gt_run",        32'(if4.run_cnt), 32'(i));
    end
    s4(1'b1, 1'b0, 1'b0);
    chk("gt_commit_state",   32'(if4.state),     32'd2);
    chk("gt_commit_changed", 32'(if4.changed),   32'd1);
    chk("gt_commit_trans",   32'(if4.trans_cnt), 32'd1);
    chk("gt_commit_run",     32'(if4.run_cnt),   32'd0);
    idle(1);
    chk("changed_drop", 32'(if4.changed), 32'd0);

    // LT,LT,GT restarts the run; then four LTs commit BELOW
    s4(1'b0, 1'b1, 1'b0);
    s4(1'b0, 1'b1, 1'b0);
    chk("lt_run2", 32'(if4.run_cnt), 32'd2);
    s4(1'b1, 1'b0, 1'b0);
    chk("restart_run",   32'(if4.run_cnt), 32'd0);
    chk("restart_state", 32'(if4.state),   32'd2);
    for (int i = 0; i < 3; i++) s4(1'b0, 1'b1, 1'b0);
    chk("lt3_state", 32'(if4.state),   32'd2);
    chk("lt3_run",   32'(if4.run_cnt), 32'd3);
    s4(1'b0, 1'b1, 1'b0);
    chk("lt_commit_state",   32'(if4.state),     32'd1);
    chk("lt_commit_changed", 32'(if4.changed),   32'd1);
    chk("lt_commit_trans",   32'(if4.trans_cnt), 32'd2);

    // gt=lt=0 is EQUAL regardless of eq
    s4(1'b0, 1'b0, 1'b0);
    s4(1'b0, 1'b0, 1'b1);
    s4(1'b0, 1'b0, 1'b0);
    chk("eq3_state", 32'(if4.state), 32'd1);
    s4(1'b0, 1'b0, 1'b0);
    chk("eq_commit_state", 32'(if4.state),     32'd0);
    chk("eq_commit_err",   32'(if4.err),       32'd0);
    chk("eq_commit_trans", 32'(if4.trans_cnt), 32'd3);

    // sample_en gap does not break a run
    s4(1'b0, 1'b1, 1'b0);
    s4(1'b0, 1'b1, 1'b0);
    idle(10);
    chk("gap_run",     32'(if4.run_cnt), 32'd2);
    chk("gap_state",   32'(if4.state),   32'd0);
    chk("gap_changed", 32'(if4.changed), 32'd0);
    s4(1'b0, 1'b1, 1'b0);
    chk("gap_run3", 32'(if4.run_cnt), 32'd3);
    s4(1'b0, 1'b1, 1'b0);
    chk("gap_commit_state", 32'(if4.state),     32'd1);
    chk("gap_commit_trans", 32'(if4.trans_cnt), 32'd4);

    // illegal flags mid-run
    s4(1'b1, 1'b0, 1'b0);
    s4(1'b1, 1'b0, 1'b0);
    chk("pre_ill_run", 32'(if4.run_cnt), 32'd2);
    s4(1'b1, 1'b1, 1'b0);
    chk("ill_err",     32'(if4.err),     32'd1);
    chk("ill_run",     32'(if4.run_cnt), 32'd0);
    chk("ill_state",   32'(if4.state),   32'd1);
    chk("ill_changed", 32'(if4.changed), 32'd0);
    s4(1'b1, 1'b0, 1'b0);
    s4(1'b1, 1'b0, 1'b0);
    s4(1'b1, 1'b0, 1'b1);
    chk("ill_eqgt_run", 32'(if4.run_cnt), 32'd0);
    for (int i = 0; i < 4; i++) s4(1'b1, 1'b0, 1'b0);
    chk("post_ill_state", 32'(if4.state),     32'd2);
    chk("post_ill_trans", 32'(if4.trans_cnt), 32'd5);
    chk("err_sticky",     32'(if4.err),       32'd1);

    // asynchronous reset in the middle of a run
    for (int i = 0; i < 3; i++) s4(1'b0, 1'b1, 1'b0);
    chk("pre_rst_run", 32'(if4.run_cnt), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(if4.state),     32'd3);
    chk("arst_run",   32'(if4.run_cnt),   32'd0);
    chk("arst_err",   32'(if4.err),       32'd0);
    chk("arst_trans", 32'(if4.trans_cnt), 32'd0);
    #2 rst = 1'b0;

    // DEBOUNCE=1: every alternating sample commits
    s1(1'b1, 1'b0);
    chk("d1_first_state",   32'(if1.state),     32'd2);
    chk("d1_first_changed", 32'(if1.changed),   32'd1);
    chk("d1_first_trans",   32'(if1.trans_cnt), 32'd1);
    changed_seen = 1;
    for (int i = 1; i < 255; i++) begin
      if (i % 2 == 0) s1(1'b1, 1'b0);
      else            s1(1'b0, 1'b1);
      if (if1.changed === 1'b1) changed_seen++;
    end
    chk("d1_trans255",  32'(if1.trans_cnt), 32'd255);
    chk("d1_state255",  32'(if1.state),     32'd2);
    chk("d1_changed_n", 32'(changed_seen),  32'd255);
    s1(1'b0, 1'b1);
    chk("d1_wrap_trans",   32'(if1.trans_cnt), 32'd0);
    chk("d1_wrap_state",   32'(if1.state),     32'd1);
    chk("d1_wrap_changed", 32'(if1.changed),   32'd1);
    s1(1'b0, 1'b1);
    chk("d1_same_changed", 32'(if1.changed),   32'd0);
    chk("d1_same_trans",   32'(if1.trans_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/compare_debounce.md
Name: compare_debounce

Overview:
- Downstream stage of the 4-bit magnitude comparator. Consumes its gt/lt/eq flags, with A as the sample and B as the threshold.
- Produces a debounced, committed relation state (ABOVE/BELOW/EQUAL). A relation is only accepted after DEBOUNCE consecutive qualifying samples.
- Also flags illegal flag combinations and counts committed transitions for status readout.

Parameters:
- DEBOUNCE, 4, consecutive identical samples required to commit a new state; legal range 1..(2^CNT_W)-1.
- CNT_W, 4, width of the run counter.
- TRANS_W, 8, width of the committed-transition counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  qualifies gt/lt/eq this cycle; flags are ignored when low.
- gt  input  1  comparator A>B flag.
- lt  input  1  comparator A<B flag.
- eq  input  1  comparator A==B flag.
- state  output  2  committed relation: 00 EQUAL, 01 BELOW, 10 ABOVE, 11 UNKNOWN.
- changed  output  1  one-cycle pulse on the cycle after a commit.
- run_cnt  output  CNT_W  current consecutive-match count for the candidate.
- err  output  1  sticky illegal-input flag.
- trans_cnt  output  TRANS_W  number of commits since reset, wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=11 (UNKNOWN), candidate=UNKNOWN, run_cnt=0, changed=0, err=0, trans_cnt=0. All registers clear immediately on rst, including mid-run; no partial run survives reset.
- Input classification, evaluated only when sample_en=1:
  - GT: gt=1, lt=0, eq=0.
  - LT: lt=1, gt=0, eq=0.
  - EQ: gt=0, lt=0. The eq value is ignored for classification, so eq=0 with gt=lt=0 is still EQ and is not an error.
  - ILLEGAL: gt=lt=1, or eq=1 together with gt or lt.
- ILLEGAL sample: err<=1, sticky until rst. run_cnt<=0, candidate<=UNKNOWN, state unchanged, no changed pulse.
- Legal sample whose class equals the committed state: run_cnt<=0, candidate<=UNKNOWN, no commit.
- Legal sample whose class equals candidate and differs from state: n = run_cnt+1.
  - If n == DEBOUNCE: commit at this edge, i.e. state<=class, run_cnt<=0, candidate<=UNKNOWN, trans_cnt<=trans_cnt+1 (mod 2^TRANS_W), changed<=1 for the following cycle.
  - Otherwise run_cnt<=n.
- Legal sample whose class differs from both candidate and state: candidate<=class, run_cnt<=1. If DEBOUNCE==1, commit immediately instead, same actions as above.
- sample_en=0: all state, candidate and run_cnt held. changed returns to 0. Gaps between samples do not break a run.
- Latency: state reflects the commit one clock after the edge carrying the DEBOUNCE-th sample is sampled, i.e. it is a registered output. changed is high in exactly that same cycle.
- Exit from UNKNOWN follows the same rule: DEBOUNCE consecutive identical legal samples.
- run_cnt never exceeds DEBOUNCE-1 at rest. It cannot saturate or wrap given the legal DEBOUNCE range.
- trans_cnt wraps from 2^TRANS_W-1 to 0 silently.
- Back-to-back commits: changed may be high on consecutive cycles only if DEBOUNCE==1 and the class alternates every cycle.
- Implementation: two-process FSM with states UNKNOWN/EQUAL/BELOW/ABOVE, plus separate candidate and counter registers. No latches; all outputs registered.

Test Plan:
- Reset, then 4 consecutive GT samples (gt=1) with DEBOUNCE=4 -> state stays 11 through samples 1-3; state=10 and changed=1 one cycle after sample 4; trans_cnt=1.
- From ABOVE: LT,LT,GT,LT,LT,LT,LT -> run restarts at the GT sample; state=01 only after the final 4 LTs; trans_cnt=2.
- gt=1,lt=1 sample mid-run (run_cnt=2) -> err=1 and stays 1, run_cnt=0, state unchanged. A subsequent legal run of 4 still commits normally.
- gt=lt=eq=0 for 4 samples from BELOW -> state=00 (EQUAL), err=0.
- LT,LT with sample_en low for 10 cycles, then LT,LT -> commit to BELOW; the gap is tolerated.
- rst asserted asynchronously mid-run (run_cnt=3), then 255 commits after release with DEBOUNCE=1 alternating GT/LT -> immediate state=11, run_cnt=0 before any clock edge; then trans_cnt=255, and 256th commit wraps trans_cnt to 0.
